// File: rtl/sdf_fft_stage.sv
// sdf_fft_stage: radix-2 DIF single-path delay-feedback FFT stage with saturating, optionally halved outputs
module sdf_fft_stage #(
  parameter int DATA_W   = 16,
  parameter int TW_W     = 16,
  parameter int FFT_N    = 1024,
  parameter int STAGE_NO = 1,
  parameter int SCALE    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sop,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  output logic                     out_sop,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im
);
  localparam int L  = FFT_N >> STAGE_NO;
  localparam int CW = $clog2(2 * L);
  localparam int KW = $clog2(FFT_N / 2);
  localparam int WW = DATA_W + TW_W + 3;
  localparam logic signed [WW-1:0] ONE  = WW'(1);
  localparam logic signed [WW-1:0] RND  = ONE <<< (TW_W - 2);
  localparam logic signed [WW-1:0] SMAX = (ONE <<< (DATA_W - 1)) - ONE;
  localparam logic signed [WW-1:0] SMIN = -(ONE <<< (DATA_W - 1));

  // Twiddle constants built by a Taylor series so the table needs no math library at elaboration
  function automatic logic signed [TW_W-1:0] tw_q(input int k, input bit im);
    real th, c, s, t, v;
    int q, lim;
    th = 6.283185307179586 * real'(k) / real'(FFT_N);
    c = 1.0;
    s = 0.0;
    t = 1.0;
    for (int n = 1; n <= 40; n++) begin
      t = t * th / real'(n);
      if (n % 4 == 1) s = s + t;
      else if (n % 4 == 2) c = c - t;
      else if (n % 4 == 3) s = s - t;
      else c = c + t;
    end
    v = (im ? -s : c) * (2.0 ** (TW_W - 1));
    q = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    lim = (1 << (TW_W - 1)) - 1;
    q = (q > lim) ? lim : (q < -lim - 1) ? -lim - 1 : q;
    return TW_W'(q);
  endfunction

  function automatic logic signed [DATA_W-1:0] fin(input logic signed [WW-1:0] v);
    logic signed [WW-1:0] s;
    s = (SCALE != 0) ? (v + ONE) >>> 1 : v;
    return (s > SMAX) ? DATA_W'(SMAX) : (s < SMIN) ? DATA_W'(SMIN) : DATA_W'(s);
  endfunction

  logic signed [TW_W-1:0] w_tw_re [FFT_N/2];
  logic signed [TW_W-1:0] w_tw_im [FFT_N/2];
  for (genvar t = 0; t < FFT_N / 2; t++) begin : g_tw
    assign w_tw_re[t] = tw_q(t, 1'b0);
    assign w_tw_im[t] = tw_q(t, 1'b1);
  end

  logic [CW-1:0]            r_cnt;
  logic                     r_primed;
  logic                     r_ov, r_os;
  logic signed [DATA_W-1:0] r_ore, r_oim;
  logic signed [DATA_W-1:0] r_dl_re [L];
  logic signed [DATA_W-1:0] r_dl_im [L];

  logic [CW-1:0]            w_cnt;
  logic                     w_ph;
  logic [KW-1:0]            w_k;
  logic signed [WW-1:0]     w_ar, w_ai, w_br, w_bi, w_sr, w_si, w_dr, w_di;
  logic signed [WW-1:0]     w_wr, w_wi, w_pr, w_pi, w_xr, w_xi;
  logic signed [DATA_W-1:0] w_tail_re, w_tail_im;

  // A qualified sop forces this sample to count position 0
  assign w_cnt = (in_valid && in_sop) ? '0 : r_cnt;
  assign w_ph  = w_cnt[CW-1];
  assign w_k   = KW'((32'(w_cnt) - L) << (STAGE_NO - 1));

  always_comb begin
    w_ar = WW'(r_dl_re[L-1]);
    w_ai = WW'(r_dl_im[L-1]);
    w_br = WW'(in_re);
    w_bi = WW'(in_im);
    w_sr = w_ar + w_br;
    w_si = w_ai + w_bi;
    w_dr = w_ar - w_br;
    w_di = w_ai - w_bi;
    w_wr = WW'(w_tw_re[w_k]);
    w_wi = WW'(w_tw_im[w_k]);
    w_pr = w_dr * w_wr - w_di * w_wi;
    w_pi = w_dr * w_wi + w_di * w_wr;
    w_xr = (w_k == '0) ? w_dr : (w_pr + RND) >>> (TW_W - 1);
    w_xi = (w_k == '0) ? w_di : (w_pi + RND) >>> (TW_W - 1);
    w_tail_re = w_ph ? fin(w_xr) : in_re;
    w_tail_im = w_ph ? fin(w_xi) : in_im;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_primed <= 1'b0;
      r_ov     <= 1'b0;
      r_os     <= 1'b0;
      r_ore    <= '0;
      r_oim    <= '0;
    end else if (in_valid) begin
      r_cnt    <= w_cnt + CW'(1);
      r_primed <= r_primed | w_ph;
      r_ov     <= r_primed | w_ph;
      r_os     <= (w_cnt == CW'(L));
      r_ore    <= w_ph ? fin(w_sr) : r_dl_re[L-1];
      r_oim    <= w_ph ? fin(w_si) : r_dl_im[L-1];
    end else begin
      r_ov <= 1'b0;
      r_os <= 1'b0;
    end
  end

  // Delay storage carries no reset; primed masks whatever it holds after rst
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int i = L - 1; i > 0; i--) begin
        r_dl_re[i] <= r_dl_re[i-1];
        r_dl_im[i] <= r_dl_im[i-1];
      end
      r_dl_re[0] <= w_tail_re;
      r_dl_im[0] <= w_tail_im;
    end
  end

  assign out_valid = r_ov;
  assign out_sop   = r_os;
  assign out_re    = r_ore;
  assign out_im    = r_oim;
endmodule
